yuv_camera_splitter: RTL and testbench

//  Sits directly upstream of the HPS DMA YUV input. Takes the camera's packed YCbCr 4:2:2 byte stream
//  (order Y0 Cb0 Y1 Cr0 ...) and splits it into three byte streams: Y, U and V.

---
 rtl/yuv_camera_splitter.sv | 212 +++++++++++++++++++++
 tb/tb_yuv_camera_splitter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/yuv_camera_splitter.sv
// Splits a packed YCbCr 4:2:2 camera byte stream into Y/U/V FIFOs, decimating chroma to 4:2:0
// (even rows only), with HPS-controlled capture through the yuv_ctrl/yuv_status PIOs.
module yuv_splitter_fifo #(
   parameter int DEPTH = 64
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       flush_i,
   input  logic       push_i,
   input  logic [7:0] data_i,
   input  logic       pop_req_i,
   output logic [7:0] data_o,
   output logic       valid_o,
   output logic       overflow_o
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] rd_ptr_q, wr_ptr_q;
   logic [AW:0]   count_q;
   logic          pop_s, full_s, push_ok_s;

   // A pop in the same cycle frees the slot, so a push into a full FIFO is only refused without one.
   assign valid_o    = (count_q != {(AW+1){1'b0}});
   assign pop_s      = valid_o && pop_req_i;
   assign full_s     = (count_q == FULL_CNT) && !pop_s;
   assign push_ok_s  = push_i && !full_s;
   assign overflow_o = push_i && full_s;
   assign data_o     = valid_o ? mem_q[rd_ptr_q] : 8'h00;

   always_ff @(posedge clk) begin
      if (push_ok_s && !flush_i) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q <= {AW{1'b0}};
         wr_ptr_q <= {AW{1'b0}};
         count_q  <= {(AW+1){1'b0}};
      end else if (flush_i) begin
         rd_ptr_q <= {AW{1'b0}};
         wr_ptr_q <= {AW{1'b0}};
         count_q  <= {(AW+1){1'b0}};
      end else begin
         if (push_ok_s) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop_s)     rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({push_ok_s, pop_s})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end
endmodule

module yuv_camera_splitter #(
   parameter int FRAME_W    = 1920,
   parameter int FRAME_H    = 1080,
   parameter int FIFO_DEPTH = 64
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] cam_data_in,
   input  logic       cam_valid_in,
   input  logic       cam_vsync_in,
   input  logic [3:0] yuv_ctrl_in,
   output logic       yuv_status_out,
   output logic       err_out,
   output logic       clear_dma_out,
   output logic [7:0] y_data_z,
   output logic       y_data_vz,
   input  logic       y_data_lz,
   output logic [7:0] u_data_z,
   output logic       u_data_vz,
   input  logic       u_data_lz,
   output logic [7:0] v_data_z,
   output logic       v_data_vz,
   input  logic       v_data_lz
);
   localparam int CW = $clog2(FRAME_W);
   localparam int RW = $clog2(FRAME_H);
   localparam logic [CW-1:0] COL_LAST = CW'(FRAME_W - 2);
   localparam logic [RW-1:0] ROW_LAST = RW'(FRAME_H - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAIT_VS = 2'd1,
      ST_CAP     = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [1:0]    phase_q;
   logic [CW-1:0] col_q;
   logic [RW-1:0] row_q;
   logic          status_q, err_q, clr_q;
   logic          capture_en_s, single_s, clear_s, unused_ctrl_s;
   logic          take_s, mid_vsync_s, restart_s, frame_end_s;
   logic          push_y_s, push_u_s, push_v_s;
   logic          ovf_y_s, ovf_u_s, ovf_v_s;

   assign capture_en_s  = yuv_ctrl_in[0];
   assign single_s      = yuv_ctrl_in[1];
   assign clear_s       = yuv_ctrl_in[2];
   assign unused_ctrl_s = yuv_ctrl_in[3];

   assign yuv_status_out = status_q;
   assign err_out        = err_q;
   assign clear_dma_out  = clr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (clear_s) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE:    state_d = capture_en_s ? ST_WAIT_VS : ST_IDLE;
            ST_WAIT_VS: begin
               if (!capture_en_s)     state_d = ST_IDLE;
               else if (cam_vsync_in) state_d = ST_CAP;
               else                   state_d = ST_WAIT_VS;
            end
            ST_CAP: begin
               if (!capture_en_s)    state_d = ST_IDLE;
               else if (frame_end_s) state_d = single_s ? ST_DONE : ST_WAIT_VS;
               else                  state_d = ST_CAP;
            end
            ST_DONE:    state_d = capture_en_s ? ST_DONE : ST_IDLE;
            default:    state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      take_s      = 1'b0;
      mid_vsync_s = 1'b0;
      if ((state_q == ST_CAP) && capture_en_s && !clear_s) begin
         take_s      = cam_valid_in;
         mid_vsync_s = cam_vsync_in;
      end else begin
         take_s      = 1'b0;
         mid_vsync_s = 1'b0;
      end
      push_y_s    = take_s && !phase_q[0];
      push_u_s    = take_s && (phase_q == 2'd1) && !row_q[0];
      push_v_s    = take_s && (phase_q == 2'd3) && !row_q[0];
      frame_end_s = take_s && (phase_q == 2'd3) && (col_q == COL_LAST) && (row_q == ROW_LAST);
      restart_s   = mid_vsync_s ||
                    ((state_q == ST_WAIT_VS) && capture_en_s && !clear_s && cam_vsync_in);
   end

   // Counters keep advancing on dropped bytes so frame alignment survives an overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q <= 2'd0;
         col_q   <= {CW{1'b0}};
         row_q   <= {RW{1'b0}};
      end else if (clear_s || restart_s) begin
         phase_q <= 2'd0;
         col_q   <= {CW{1'b0}};
         row_q   <= {RW{1'b0}};
      end else if (take_s) begin
         phase_q <= phase_q + 2'd1;
         if (phase_q == 2'd3) begin
            if (col_q == COL_LAST) begin
               col_q <= {CW{1'b0}};
               row_q <= (row_q == ROW_LAST) ? {RW{1'b0}} : row_q + RW'(1);
            end else begin
               col_q <= col_q + CW'(2);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         status_q <= 1'b0;
         err_q    <= 1'b0;
         clr_q    <= 1'b0;
      end else begin
         clr_q <= clear_s;
         if (clear_s) begin
            status_q <= 1'b0;
            err_q    <= 1'b0;
         end else begin
            if (frame_end_s) status_q <= 1'b1;
            if (mid_vsync_s || ovf_y_s || ovf_u_s || ovf_v_s) err_q <= 1'b1;
         end
      end
   end

   yuv_splitter_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo_y (
      .clk(clk), .rst_n(rst_n), .flush_i(clear_s), .push_i(push_y_s), .data_i(cam_data_in),
      .pop_req_i(y_data_lz), .data_o(y_data_z), .valid_o(y_data_vz), .overflow_o(ovf_y_s)
   );
   yuv_splitter_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo_u (
      .clk(clk), .rst_n(rst_n), .flush_i(clear_s), .push_i(push_u_s), .data_i(cam_data_in),
      .pop_req_i(u_data_lz), .data_o(u_data_z), .valid_o(u_data_vz), .overflow_o(ovf_u_s)
   );
   yuv_splitter_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo_v (
      .clk(clk), .rst_n(rst_n), .flush_i(clear_s), .push_i(push_v_s), .data_i(cam_data_in),
      .pop_req_i(v_data_lz), .data_o(v_data_z), .valid_o(v_data_vz), .overflow_o(ovf_v_s)
   );
endmodule

// File: tb/tb_yuv_camera_splitter.sv
// Directed bench for yuv_camera_splitter on a 4x2 frame with 4-entry FIFOs.
module tb_yuv_camera_splitter;
   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] cam_data_in;
   logic       cam_valid_in, cam_vsync_in;
   logic [3:0] yuv_ctrl_in;
   logic       yuv_status_out, err_out, clear_dma_out;
   logic [7:0] y_data_z, u_data_z, v_data_z;
   logic       y_data_vz, u_data_vz, v_data_vz;
   logic       y_data_lz, u_data_lz, v_data_lz;

   int total = 0;
   int bad   = 0;
   logic [7:0] ygot[$], ugot[$], vgot[$];

   always #5 clk = ~clk;

   yuv_camera_splitter #(.FRAME_W(4), .FRAME_H(2), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .cam_data_in(cam_data_in), .cam_valid_in(cam_valid_in),
      .cam_vsync_in(cam_vsync_in), .yuv_ctrl_in(yuv_ctrl_in), .yuv_status_out(yuv_status_out),
      .err_out(err_out), .clear_dma_out(clear_dma_out),
      .y_data_z(y_data_z), .y_data_vz(y_data_vz), .y_data_lz(y_data_lz),
      .u_data_z(u_data_z), .u_data_vz(u_data_vz), .u_data_lz(u_data_lz),
      .v_data_z(v_data_z), .v_data_vz(v_data_vz), .v_data_lz(v_data_lz)
   );

   // Records every byte the sink accepts.
   always @(negedge clk) begin
      if (rst_n) begin
         if (y_data_vz && y_data_lz) ygot.push_back(y_data_z);
         if (u_data_vz && u_data_lz) ugot.push_back(u_data_z);
         if (v_data_vz && v_data_lz) vgot.push_back(v_data_z);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      cam_data_in  = b;
      cam_valid_in = 1'b1;
      tick();
      cam_valid_in = 1'b0;
   endtask

   task automatic send_vsync();
      cam_vsync_in = 1'b1;
      tick();
      cam_vsync_in = 1'b0;
   endtask

   task automatic start_test(input logic [3:0] ctrl);
      yuv_ctrl_in = 4'b0100;
      tick();
      yuv_ctrl_in = ctrl;
      tick();
      ygot.delete();
      ugot.delete();
      vgot.delete();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      total++;
      if ({yuv_status_out, err_out, clear_dma_out, y_data_vz, u_data_vz, v_data_vz} !== 6'b0) begin
         bad++;
         $display("FAIL reset_flags: got %b want 000000",
                  {yuv_status_out, err_out, clear_dma_out, y_data_vz, u_data_vz, v_data_vz});
      end
      total++;
      if ({y_data_z, u_data_z, v_data_z} !== 24'h0) begin
         bad++;
         $display("FAIL reset_data: got %h want 000000", {y_data_z, u_data_z, v_data_z});
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single_frame();
      logic [7:0] ey[$], eu[$], ev[$], g;
      ey = '{8'h00, 8'h02, 8'h04, 8'h06, 8'h08, 8'h0A, 8'h0C, 8'h0E};
      eu = '{8'h01, 8'h05};
      ev = '{8'h03, 8'h07};
      start_test(4'b0011);
      send_vsync();
      total++;
      if (y_data_vz !== 1'b0) begin bad++; $display("FAIL sf_empty: got %b want 0", y_data_vz); end
      send_byte(8'h00);
      total++;
      if ({y_data_vz, y_data_z} !== {1'b1, 8'h00}) begin
         bad++; $display("FAIL sf_latency: got %b/%h want 1/00", y_data_vz, y_data_z);
      end
      for (int b = 1; b < 15; b++) send_byte(8'(b));
      total++;
      if (yuv_status_out !== 1'b0) begin bad++; $display("FAIL sf_status_early: got %b want 0", yuv_status_out); end
      send_byte(8'h0F);
      total++;
      if (yuv_status_out !== 1'b1) begin bad++; $display("FAIL sf_status_end: got %b want 1", yuv_status_out); end
      for (int b = 16; b < 20; b++) send_byte(8'(b));
      for (int i = 0; i < 4; i++) tick();
      total++;
      if (err_out !== 1'b0) begin bad++; $display("FAIL sf_err: got %b want 0", err_out); end
      total++;
      if ({ygot.size(), ugot.size(), vgot.size()} !== {32'd8, 32'd2, 32'd2}) begin
         bad++; $display("FAIL sf_counts: got %0d/%0d/%0d want 8/2/2", ygot.size(), ugot.size(), vgot.size());
      end
      foreach (ey[i]) begin
         g = (i < ygot.size()) ? ygot[i] : 8'hxx;
         total++;
         if (g !== ey[i]) begin bad++; $display("FAIL sf_y[%0d]: got %h want %h", i, g, ey[i]); end
      end
      foreach (eu[i]) begin
         g = (i < ugot.size()) ? ugot[i] : 8'hxx;
         total++;
         if (g !== eu[i]) begin bad++; $display("FAIL sf_u[%0d]: got %h want %h", i, g, eu[i]); end
      end
      foreach (ev[i]) begin
         g = (i < vgot.size()) ? vgot[i] : 8'hxx;
         total++;
         if (g !== ev[i]) begin bad++; $display("FAIL sf_v[%0d]: got %h want %h", i, g, ev[i]); end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] eu[$], ev[$], g, ey;
      eu = '{8'h01, 8'h05, 8'h11, 8'h15};
      ev = '{8'h03, 8'h07, 8'h13, 8'h17};
      start_test(4'b0001);
      send_vsync();
      for (int b = 0; b < 16; b++) send_byte(8'(b));
      total++;
      if (yuv_status_out !== 1'b1) begin bad++; $display("FAIL b2b_status1: got %b want 1", yuv_status_out); end
      send_vsync();
      for (int b = 16; b < 32; b++) send_byte(8'(b));
      for (int i = 0; i < 4; i++) tick();
      total++;
      if ({yuv_status_out, err_out} !== 2'b10) begin
         bad++; $display("FAIL b2b_flags: got %b want 10", {yuv_status_out, err_out});
      end
      total++;
      if ({ygot.size(), ugot.size(), vgot.size()} !== {32'd16, 32'd4, 32'd4}) begin
         bad++; $display("FAIL b2b_counts: got %0d/%0d/%0d want 16/4/4", ygot.size(), ugot.size(), vgot.size());
      end
      for (int i = 0; i < 16; i++) begin
         ey = 8'(2 * i);
         g  = (i < ygot.size()) ? ygot[i] : 8'hxx;
         total++;
         if (g !== ey) begin bad++; $display("FAIL b2b_y[%0d]: got %h want %h", i, g, ey); end
      end
      foreach (eu[i]) begin
         g = (i < ugot.size()) ? ugot[i] : 8'hxx;
         total++;
         if (g !== eu[i]) begin bad++; $display("FAIL b2b_u[%0d]: got %h want %h", i, g, eu[i]); end
      end
      foreach (ev[i]) begin
         g = (i < vgot.size()) ? vgot[i] : 8'hxx;
         total++;
         if (g !== ev[i]) begin bad++; $display("FAIL b2b_v[%0d]: got %h want %h", i, g, ev[i]); end
      end
   endtask

   task automatic test_overflow();
      logic [7:0] ey[$], g;
      ey = '{8'h00, 8'h02, 8'h04, 8'h06};
      y_data_lz = 1'b0;
      start_test(4'b0011);
      send_vsync();
      for (int b = 0; b < 8; b++) send_byte(8'(b));
      total++;
      if ({err_out, y_data_vz, y_data_z} !== {1'b0, 1'b1, 8'h00}) begin
         bad++; $display("FAIL ovf_full: got %b/%b/%h want 0/1/00", err_out, y_data_vz, y_data_z);
      end
      send_byte(8'h08);
      total++;
      if ({err_out, y_data_z} !== {1'b1, 8'h00}) begin
         bad++; $display("FAIL ovf_drop: got %b/%h want 1/00", err_out, y_data_z);
      end
      for (int b = 9; b < 12; b++) send_byte(8'(b));
      y_data_lz = 1'b1;
      for (int i = 0; i < 6; i++) tick();
      total++;
      if (ygot.size() != 4) begin bad++; $display("FAIL ovf_ycount: got %0d want 4", ygot.size()); end
      foreach (ey[i]) begin
         g = (i < ygot.size()) ? ygot[i] : 8'hxx;
         total++;
         if (g !== ey[i]) begin bad++; $display("FAIL ovf_y[%0d]: got %h want %h", i, g, ey[i]); end
      end
      total++;
      if ({ugot.size(), vgot.size()} !== {32'd2, 32'd2}) begin
         bad++; $display("FAIL ovf_uv_count: got %0d/%0d want 2/2", ugot.size(), vgot.size());
      end
      total++;
      if ({ugot[0], ugot[1], vgot[0], vgot[1]} !== 32'h01050307) begin
         bad++; $display("FAIL ovf_uv: got %h%h%h%h want 01050307", ugot[0], ugot[1], vgot[0], vgot[1]);
      end
   endtask

   task automatic test_vsync_mid();
      start_test(4'b0011);
      send_vsync();
      for (int b = 0; b < 5; b++) send_byte(8'(b));
      total++;
      if (err_out !== 1'b0) begin bad++; $display("FAIL vs_err_before: got %b want 0", err_out); end
      send_vsync();
      total++;
      if (err_out !== 1'b1) begin bad++; $display("FAIL vs_err_after: got %b want 1", err_out); end
      send_byte(8'hA0);
      send_byte(8'hA1);
      for (int i = 0; i < 4; i++) tick();
      total++;
      if ({ygot.size(), ugot.size(), vgot.size()} !== {32'd4, 32'd2, 32'd1}) begin
         bad++; $display("FAIL vs_counts: got %0d/%0d/%0d want 4/2/1", ygot.size(), ugot.size(), vgot.size());
      end
      total++;
      if ({ygot[3], ugot[1], ugot[0], vgot[0]} !== 32'hA0A10103) begin
         bad++; $display("FAIL vs_route: got %h%h%h%h want A0A10103", ygot[3], ugot[1], ugot[0], vgot[0]);
      end
   endtask

   task automatic test_clear();
      y_data_lz = 1'b0; u_data_lz = 1'b0; v_data_lz = 1'b0;
      start_test(4'b0011);
      send_vsync();
      for (int b = 0; b < 16; b++) send_byte(8'(b));
      total++;
      if ({yuv_status_out, err_out, y_data_vz, u_data_vz, v_data_vz} !== 5'b11111) begin
         bad++; $display("FAIL clr_pre: got %b want 11111",
                         {yuv_status_out, err_out, y_data_vz, u_data_vz, v_data_vz});
      end
      yuv_ctrl_in = 4'b0111;
      tick();
      total++;
      if ({yuv_status_out, err_out, y_data_vz, u_data_vz, v_data_vz, clear_dma_out} !== 6'b000001) begin
         bad++; $display("FAIL clr_post: got %b want 000001",
                         {yuv_status_out, err_out, y_data_vz, u_data_vz, v_data_vz, clear_dma_out});
      end
      yuv_ctrl_in = 4'b0011;
      tick();
      total++;
      if ({clear_dma_out, y_data_vz} !== 2'b00) begin
         bad++; $display("FAIL clr_release: got %b want 00", {clear_dma_out, y_data_vz});
      end
      y_data_lz = 1'b1; u_data_lz = 1'b1; v_data_lz = 1'b1;
   endtask

   task automatic test_reset_mid_cap();
      y_data_lz = 1'b0; u_data_lz = 1'b0; v_data_lz = 1'b0;
      start_test(4'b0011);
      send_vsync();
      for (int b = 0; b < 3; b++) send_byte(8'(b + 8'h40));
      total++;
      if ({y_data_vz, u_data_vz} !== 2'b11) begin
         bad++; $display("FAIL rst_pre: got %b want 11", {y_data_vz, u_data_vz});
      end
      rst_n = 1'b0;
      #1;
      total++;
      if ({yuv_status_out, err_out, clear_dma_out, y_data_vz, u_data_vz, v_data_vz,
           y_data_z, u_data_z, v_data_z} !== 30'h0) begin
         bad++; $display("FAIL rst_mid: got vz=%b%b%b y=%h u=%h want all 0",
                         y_data_vz, u_data_vz, v_data_vz, y_data_z, u_data_z);
      end
      #2;
      rst_n = 1'b1;
      tick();
      send_byte(8'h55);
      total++;
      if ({y_data_vz, u_data_vz, v_data_vz} !== 3'b000) begin
         bad++; $display("FAIL rst_idle: got %b want 000", {y_data_vz, u_data_vz, v_data_vz});
      end
      y_data_lz = 1'b1; u_data_lz = 1'b1; v_data_lz = 1'b1;
   endtask

   initial begin
      cam_data_in  = 8'h00;
      cam_valid_in = 1'b0;
      cam_vsync_in = 1'b0;
      yuv_ctrl_in  = 4'b0000;
      y_data_lz    = 1'b1;
      u_data_lz    = 1'b1;
      v_data_lz    = 1'b1;
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_overflow();
      test_vsync_mid();
      test_clear();
      test_reset_mid_cap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
